// File: rtl/firebird7_in_gate2_ijtag_access_ctrl.sv
// rtl/firebird7_in_gate2_ijtag_access_ctrl.sv - IJTAG initiator driving the gate2 network control pins
// Runs one capture/shift/update command per handshake and returns the scanned-out vector.
module firebird7_in_gate2_ijtag_access_ctrl #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               ijtag_tck,
  input  logic               ijtag_reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               cmd_capture,
  input  logic               cmd_update,
  input  logic [MAX_LEN-1:0] cmd_si,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_so,
  output logic               ijtag_sel,
  output logic               ijtag_ce,
  output logic               ijtag_se,
  output logic               ijtag_ue,
  output logic               ijtag_si,
  input  logic               ijtag_so
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SHIFT,
    UPDATE,
    RESP
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_d;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   cnt_nxt;
  logic               capture_q;
  logic               capture_d;
  logic               update_q;
  logic               update_d;
  logic [MAX_LEN-1:0] si_q;
  logic [MAX_LEN-1:0] si_d;
  logic [MAX_LEN-1:0] so_d;
  logic [IDX_W-1:0]   so_idx;
  logic [IDX_W-1:0]   si_idx;
  logic               sel_d;
  logic               ce_d;
  logic               se_d;
  logic               ue_d;
  logic               si_bit_d;

  // First enabled phase in CAPTURE, SHIFT, UPDATE order; RESP when none remain.
  function automatic state_t first_phase(input logic cap, input logic shf, input logic upd);
    if (cap) return CAPTURE;
    else if (shf) return SHIFT;
    else if (upd) return UPDATE;
    else return RESP;
  endfunction

  always_comb begin
    state_nxt = state;
    len_d     = len_q;
    capture_d = capture_q;
    update_d  = update_q;
    si_d      = si_q;
    cnt_nxt   = cnt;
    so_d      = rsp_so;
    so_idx    = cnt[IDX_W-1:0];

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          len_d     = (cmd_len > MAX_LEN_V) ? MAX_LEN_V : cmd_len;
          capture_d = cmd_capture;
          update_d  = cmd_update;
          si_d      = cmd_si;
          so_d      = '0;
          cnt_nxt   = '0;
          state_nxt = first_phase(cmd_capture, len_d != '0, cmd_update);
        end
      end
      CAPTURE: state_nxt = first_phase(1'b0, len_q != '0, update_q);
      SHIFT: begin
        so_d[so_idx] = ijtag_so;
        if (cnt == len_q - 1'b1) begin
          cnt_nxt   = '0;
          state_nxt = update_q ? UPDATE : RESP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      UPDATE: state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Pin values are decoded from the upcoming state so every output leaves a flop.
    sel_d    = (state_nxt == CAPTURE) || (state_nxt == SHIFT) || (state_nxt == UPDATE);
    ce_d     = (state_nxt == CAPTURE);
    se_d     = (state_nxt == SHIFT);
    ue_d     = (state_nxt == UPDATE);
    si_idx   = cnt_nxt[IDX_W-1:0];
    si_bit_d = se_d ? si_d[si_idx] : 1'b0;
  end

  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      state     <= IDLE;
      len_q     <= '0;
      cnt       <= '0;
      capture_q <= 1'b0;
      update_q  <= 1'b0;
      si_q      <= '0;
      rsp_so    <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      ijtag_sel <= 1'b0;
      ijtag_ce  <= 1'b0;
      ijtag_se  <= 1'b0;
      ijtag_ue  <= 1'b0;
      ijtag_si  <= 1'b0;
    end else begin
      state     <= state_nxt;
      len_q     <= len_d;
      cnt       <= cnt_nxt;
      capture_q <= capture_d;
      update_q  <= update_d;
      si_q      <= si_d;
      rsp_so    <= so_d;
      cmd_ready <= (state_nxt == IDLE);
      rsp_valid <= (state_nxt == RESP);
      ijtag_sel <= sel_d;
      ijtag_ce  <= ce_d;
      ijtag_se  <= se_d;
      ijtag_ue  <= ue_d;
      ijtag_si  <= si_bit_d;
    end
  end

endmodule

// File: tb/tb_firebird7_in_gate2_ijtag_access_ctrl.sv
// tb/tb_firebird7_in_gate2_ijtag_access_ctrl.sv - bench for the gate2 IJTAG initiator
// A behavioural scan-chain model answers on ijtag_so; expected responses are queued per command.
module tb_firebird7_in_gate2_ijtag_access_ctrl;

  localparam int MAX_LEN = 64;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               ijtag_tck = 1'b0;
  logic               ijtag_reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [LEN_W-1:0]   cmd_len;
  logic               cmd_capture;
  logic               cmd_update;
  logic [MAX_LEN-1:0] cmd_si;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_so;
  logic               ijtag_sel;
  logic               ijtag_ce;
  logic               ijtag_se;
  logic               ijtag_ue;
  logic               ijtag_si;
  logic               net_so = 1'b0;

  firebird7_in_gate2_ijtag_access_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .ijtag_tck   (ijtag_tck),
    .ijtag_reset (ijtag_reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_len     (cmd_len),
    .cmd_capture (cmd_capture),
    .cmd_update  (cmd_update),
    .cmd_si      (cmd_si),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_so      (rsp_so),
    .ijtag_sel   (ijtag_sel),
    .ijtag_ce    (ijtag_ce),
    .ijtag_se    (ijtag_se),
    .ijtag_ue    (ijtag_ue),
    .ijtag_si    (ijtag_si),
    .ijtag_so    (net_so)
  );

  always #5 ijtag_tck = ~ijtag_tck;

  // Network: net_len-bit chain, loads net_cap on capture, scan-out retimed on the falling edge.
  int          net_len   = 4;
  logic [63:0] net_cap   = '0;
  logic [63:0] net_chain = '0;

  always @(posedge ijtag_tck) begin
    if (ijtag_ce) net_chain <= net_cap;
    else if (ijtag_se) net_chain <= (net_chain >> 1) | (64'(ijtag_si) << (net_len - 1));
  end

  always @(negedge ijtag_tck) net_so <= net_chain[0];

  typedef struct {
    int          id;
    logic [63:0] so;
    int          lat;
    int          ce;
    int          se;
    int          ue;
  } exp_t;

  typedef struct {
    int          nl;
    logic [63:0] cv;
    int          len;
    logic        cap;
    logic        upd;
    logic [63:0] si;
    logic [63:0] so;
    int          lat;
    int          ce;
    int          se;
    int          ue;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[9];
  int          checks = 0;
  int          errors = 0;
  int          cmd_id = 0;
  bit          busy = 1'b0;
  bit          lat_seen;
  int          cyc, lat, n_ce, n_se, n_ue, n_sel, n_ovl, n_rdy, n_unstable;
  logic [63:0] so_first;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] so, input int lat_e, input int ce, input int se, input int ue);
    exp_t e;
    e.id = cmd_id; e.so = so; e.lat = lat_e; e.ce = ce; e.se = se; e.ue = ue;
    sb_q.push_back(e);
    cmd_id++;
  endtask

  // Resolves the handshakes the coming rising edge will take, then samples the next cycle.
  task automatic step();
    exp_t e;
    if (rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp actual=1 required=0");
      end else begin
        e = sb_q.pop_front();
        check($sformatf("cmd%0d_so", e.id), rsp_so, e.so);
        check($sformatf("cmd%0d_lat", e.id), lat, e.lat);
        check($sformatf("cmd%0d_ce_cycles", e.id), n_ce, e.ce);
        check($sformatf("cmd%0d_se_cycles", e.id), n_se, e.se);
        check($sformatf("cmd%0d_ue_cycles", e.id), n_ue, e.ue);
        check($sformatf("cmd%0d_sel_cycles", e.id), n_sel, e.ce + e.se + e.ue);
        check($sformatf("cmd%0d_overlap", e.id), n_ovl, 0);
        check($sformatf("cmd%0d_ready_busy", e.id), n_rdy, 0);
        check($sformatf("cmd%0d_so_unstable", e.id), n_unstable, 0);
      end
      busy = 1'b0;
    end
    if (cmd_valid && cmd_ready) begin
      busy = 1'b1; cyc = 0; lat = -1; lat_seen = 1'b0;
      n_ce = 0; n_se = 0; n_ue = 0; n_sel = 0; n_ovl = 0; n_rdy = 0; n_unstable = 0;
    end
    @(negedge ijtag_tck);
    cyc++;
    if (busy) begin
      if (ijtag_ce) n_ce++;
      if (ijtag_se) n_se++;
      if (ijtag_ue) n_ue++;
      if (ijtag_sel) n_sel++;
      if ($countones({ijtag_ce, ijtag_se, ijtag_ue}) > 1) n_ovl++;
      if (cmd_ready) n_rdy++;
      if (rsp_valid) begin
        if (!lat_seen) begin
          lat_seen = 1'b1; lat = cyc; so_first = rsp_so;
        end else if (rsp_so !== so_first) begin
          n_unstable++;
        end
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 200) begin step(); n++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL timeout_cmd_ready actual=0 required=1");
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin step(); n++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL timeout_response actual=busy required=done");
      busy = 1'b0;
      sb_q.delete();
    end
  endtask

  task automatic set_vec(input int i, input int nl, input logic [63:0] cv, input int len,
                         input logic cap, input logic upd, input logic [63:0] si,
                         input logic [63:0] so, input int lat_e, input int ce, input int se, input int ue);
    vecs[i].nl = nl; vecs[i].cv = cv; vecs[i].len = len; vecs[i].cap = cap; vecs[i].upd = upd;
    vecs[i].si = si; vecs[i].so = so; vecs[i].lat = lat_e; vecs[i].ce = ce; vecs[i].se = se; vecs[i].ue = ue;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // nl, capture value, len, cap, upd, si  ->  rsp_so, latency, ce/se/ue cycles
    set_vec(0, 4,  64'hF,                 8,  1, 1, 64'hA5,                 64'h5F,                 11, 1, 8,  1);
    set_vec(1, 4,  64'h9,                 0,  1, 0, 64'h0,                  64'h0,                  2,  1, 0,  0);
    set_vec(2, 4,  64'h9,                 1,  0, 0, 64'h1,                  64'h1,                  2,  0, 1,  0);
    set_vec(3, 64, 64'hDEADBEEF_01234567, 67, 1, 1, 64'h01234567_89ABCDEF, 64'hDEADBEEF_01234567, 67, 1, 64, 1);
    set_vec(4, 4,  64'h0,                 0,  0, 0, 64'hFFFF,               64'h0,                  1,  0, 0,  0);
    set_vec(5, 4,  64'hF,                 0,  1, 1, 64'hFF,                 64'h0,                  3,  1, 0,  1);
    set_vec(6, 4,  64'h3,                 6,  1, 0, 64'h2D,                 64'h13,                 8,  1, 6,  0);
    set_vec(7, 4,  64'h3,                 0,  0, 1, 64'h0,                  64'h0,                  2,  0, 0,  1);
    set_vec(8, 4,  64'h3,                 5,  0, 1, 64'h06,                 64'h0B,                 7,  0, 5,  1);

    ijtag_reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_capture = 1'b0;
    cmd_update = 1'b0; cmd_si = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge ijtag_tck);
    ijtag_reset = 1'b0;
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_so", rsp_so, 0);
    check("reset_ijtag_pins", {ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si}, 0);
    step();

    // Reset dropped in the middle of a 40-bit shift at k=10.
    net_len = 4; net_cap = 64'hF;
    cmd_len = LEN_W'(40); cmd_capture = 1'b1; cmd_update = 1'b1; cmd_si = '1; cmd_valid = 1'b1;
    wait_ready();
    step();
    cmd_valid = 1'b0;
    begin
      int n = 0;
      while (!ijtag_se && n < 20) begin step(); n++; end
    end
    check("rst_shift_started", ijtag_se, 1);
    repeat (10) step();
    check("rst_pins_before", {ijtag_sel, ijtag_se, ijtag_si}, 3'b111);
    #1 ijtag_reset = 1'b1;
    #1;
    check("rst_pins_async", {ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si}, 0);
    check("rst_rsp_valid_async", rsp_valid, 0);
    check("rst_cmd_ready_async", cmd_ready, 1);
    busy = 1'b0;
    repeat (2) @(negedge ijtag_tck);
    ijtag_reset = 1'b0;
    repeat (3) step();
    check("rst_rsp_valid_after", rsp_valid, 0);
    check("rst_cmd_ready_after", cmd_ready, 1);

    for (int i = 0; i < 9; i++) begin
      net_len = vecs[i].nl;
      net_cap = vecs[i].cv;
      push_exp(vecs[i].so, vecs[i].lat, vecs[i].ce, vecs[i].se, vecs[i].ue);
      cmd_len = LEN_W'(vecs[i].len); cmd_capture = vecs[i].cap; cmd_update = vecs[i].upd;
      cmd_si = vecs[i].si; cmd_valid = 1'b1;
      wait_ready();
      step();
      cmd_valid = 1'b0;
      wait_idle();
    end

    // Response backpressure with the next command already waiting.
    net_len = 4; net_cap = 64'h6;
    push_exp(64'h6, 7, 1, 4, 1);
    push_exp(64'h2, 4, 1, 2, 0);
    cmd_len = LEN_W'(4); cmd_capture = 1'b1; cmd_update = 1'b1; cmd_si = '0;
    cmd_valid = 1'b1; rsp_ready = 1'b0;
    wait_ready();
    step();
    cmd_len = LEN_W'(2); cmd_capture = 1'b1; cmd_update = 1'b0; cmd_si = '1;
    begin
      int n = 0;
      while (!rsp_valid && n < 50) begin step(); n++; end
    end
    check("bp_rsp_valid", rsp_valid, 1);
    repeat (5) step();
    check("bp_rsp_valid_held", rsp_valid, 1);
    check("bp_cmd_ready_held", cmd_ready, 0);
    rsp_ready = 1'b1;
    step();
    check("bp_gap_sel", ijtag_sel, 0);
    check("bp_gap_cmd_ready", cmd_ready, 1);
    step();
    check("bp_next_ce", ijtag_ce, 1);
    check("bp_next_sel", ijtag_sel, 1);
    cmd_valid = 1'b0;
    wait_idle();

    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/firebird7_in_gate2_ijtag_access_ctrl.md
# firebird7_in_gate2_ijtag_access_ctrl

IJTAG initiator for the gate2 instrument network: accepts a capture/shift/update command on a valid/ready interface, drives the network's select, capture, shift, update and scan-in pins, samples the network's scan-out, and returns the shifted-out vector on a response handshake. It sits on the host side of the gate2 IJTAG chain, directly above the top segment-insertion bits, and is the only driver of their control pins.

## Interface
- MAX_LEN, 64: longest shift supported per command; sets the width of the scan-data fields.
- LEN_W, $clog2(MAX_LEN+1): width of cmd_len.
- ijtag_tck  in  1  clock; all state changes on the rising edge.
- ijtag_reset  in  1  reset, asynchronous and active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller idle and able to accept a command.
- cmd_len  in  LEN_W  number of shift cycles; values above MAX_LEN are clamped to MAX_LEN.
- cmd_capture  in  1  perform the capture cycle before shifting.
- cmd_update  in  1  perform the update cycle after shifting.
- cmd_si  in  MAX_LEN  scan-in data; bit 0 is shifted first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_so  out  MAX_LEN  scan-out data; bit k was sampled on shift edge k. Bits at and above the effective length are 0.
- ijtag_sel  out  1  network select.
- ijtag_ce  out  1  capture enable.
- ijtag_se  out  1  shift enable.
- ijtag_ue  out  1  update enable.
- ijtag_si  out  1  serial data into the network.
- ijtag_so  in  1  serial data from the network; retimed by the network on the falling edge.

## Operation
- FSM states: IDLE, CAPTURE, SHIFT, UPDATE, RESP.
- IDLE
  - cmd_ready=1; all ijtag_* outputs are 0.
  - On cmd_valid&cmd_ready, latch cmd_si, clamped cmd_len, cmd_capture and cmd_update, and clear rsp_so.
  - Next state is the first enabled phase, in the order CAPTURE, SHIFT (taken only if len>0), UPDATE. If no phase is enabled, go to RESP.
- CAPTURE: one cycle with sel=1, ce=1, se=0, ue=0.
- SHIFT
  - Lasts len cycles with sel=1, se=1.
  - ijtag_si = latched bit k during shift cycle k.
  - On the rising edge that ends shift cycle k, ijtag_so is written into rsp_so[k].
  - A 7-bit counter tracks k and wraps to 0 on exit.
- UPDATE: one cycle with sel=1, ue=1.
- RESP
  - rsp_valid=1 and all ijtag_* outputs are 0.
  - rsp_so is held stable until rsp_valid&rsp_ready; the FSM then returns to IDLE.
- sel stays 1 continuously from the first active phase through the last active phase, with no gap between phases.
- ce, se and ue are mutually exclusive.
- New commands are not accepted while busy: cmd_ready=0 in every state except IDLE.

## Timing
- All outputs are registered.
- Reset values: cmd_ready=1; rsp_valid=0; rsp_so=0; all ijtag_* outputs = 0; state IDLE.
- Accept edge E0: CAPTURE occupies the cycle after E0 (c1). SHIFT occupies cycles c2..c(len+1). UPDATE occupies c(len+2). rsp_valid rises at the start of c(len+3).
  - Each skipped phase removes its cycle from this count.
- The minimum round trip, with no phases enabled, is rsp_valid one cycle after E0.
- The response handshake completes on the edge where rsp_valid&rsp_ready. cmd_ready=1 in the following cycle.
  - Back-to-back commands therefore have at least one cycle of sel=0 between them. The network needs this gap to propagate its select-enable change.
- ijtag_si changes only on rising edges. The network samples it on the next rising edge.
- Reset mid-operation: asynchronous return to the reset values. The in-flight command is dropped and no response is produced.
- len=0 with capture and update both set: capture cycle, then update cycle, then rsp_so=0.
- len=MAX_LEN (and any larger request): exactly MAX_LEN shift cycles. The counter must not overflow at this length.

## Test plan
- **Reset:** assert reset mid-SHIFT with len=40 at k=10 -> all ijtag_* outputs fall to 0 immediately, rsp_valid stays 0, cmd_ready=1 after reset releases.
- **Full sequence:** capture=1, update=1, len=8, si=0xA5, with a loopback model returning so = si delayed by 4 bits with captured bits 0xF -> ce for 1 cycle, se for 8 cycles, ue for 1 cycle, rsp_so=0x5F, rsp_valid in cycle 11.
- **Shift only:** capture=0, update=0, len=1, si=1 -> exactly one cycle of sel=1/se=1 with ce and ue never asserted, rsp_valid in cycle 2.
- **Clamp:** len=MAX_LEN+3 on a 64-bit chain -> exactly 64 se cycles, rsp_so equal to the model's 64-bit captured pattern 0xDEADBEEF_01234567.
- **Response backpressure:** hold rsp_ready=0 for 5 cycles with cmd_valid held high -> rsp_so stable and cmd_ready=0 throughout. After the handshake there is one IDLE cycle with sel=0, then the next command starts its capture.
- **Empty command:** len=0, capture=0, update=0 -> ijtag_sel never asserted, rsp_valid one cycle after accept, rsp_so=0.
